// File: rtl/soc_int_arbiter_pkg.sv
// Shared types and default sizing for the SoC interrupt arbiter.
package intarb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OFFER,
        ARB_SERVING
    } intarb_state_t;

    localparam int INTARB_NUM_INTS = 32;
    localparam int INTARB_TIMEOUT  = 1024;

endpackage

// File: rtl/soc_prio_encoder.sv
// Combinational priority encoder: first set request at or after i_start,
// wrapping modulo W. Tie i_start to zero for plain lowest-index priority.
module soc_prio_encoder #(
    parameter  int W   = 32,
    localparam int IDW = $clog2(W)
) (
    input  logic [W-1:0]   i_req,
    input  logic [IDW-1:0] i_start,
    output logic           o_found,
    output logic [IDW-1:0] o_idx
);

    int             w_j;
    logic [IDW-1:0] w_pos;

    // Walk the rotated order backwards so the earliest hit is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_j     = 0;
        w_pos   = '0;
        for (int k = W - 1; k >= 0; k--) begin
            w_j = int'(i_start) + k;
            if (w_j >= W) begin
                w_j = w_j - W;
            end
            w_pos = w_j[IDW-1:0];
            if (i_req[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/soc_int_arbiter.sv
// Offers pending SoC interrupts to the core one at a time and tracks the service window.
// Define INT_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index priority.
module soc_int_arbiter
    import intarb_pkg::*;
#(
    parameter  int NUM_INTS       = INTARB_NUM_INTS,
    parameter  int TIMEOUT_CYCLES = INTARB_TIMEOUT,
    localparam int ID_W           = $clog2(NUM_INTS)
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic [NUM_INTS-1:0] pending_ints,
    output logic                irq_valid,
    output logic [ID_W-1:0]     irq_id,
    input  logic                irq_ack,
    input  logic                irq_done,
    output logic [NUM_INTS-1:0] int_clears,
    output logic                busy,
    output logic                timeout_pulse
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    intarb_state_t       r_state;
    logic                r_valid;
    logic [ID_W-1:0]     r_id;
    logic [NUM_INTS-1:0] r_clears;
    logic                r_tpulse;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_found;
    logic [ID_W-1:0]     w_win;
    logic [ID_W-1:0]     w_start;

`ifdef INT_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_ptr;

    // Search resumes just past the most recently claimed line.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_ptr <= '0;
        end else if (r_state == ARB_OFFER && irq_ack) begin
            r_ptr <= (r_id == ID_W'(NUM_INTS - 1)) ? '0 : r_id + 1'b1;
        end
    end

    assign w_start = r_ptr;
`else
    assign w_start = '0;
`endif

    soc_prio_encoder #(
        .W (NUM_INTS)
    ) u_prio_enc (
        .i_req   (pending_ints),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_win)
    );

    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_state  <= ARB_IDLE;
            r_valid  <= 1'b0;
            r_id     <= '0;
            r_clears <= '0;
            r_tpulse <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_clears <= '0;
            r_tpulse <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_id    <= w_win;
                        r_valid <= 1'b1;
                        r_state <= ARB_OFFER;
                    end
                end
                ARB_OFFER: begin
                    // Ack takes precedence over a simultaneous software withdrawal.
                    if (irq_ack) begin
                        r_clears <= NUM_INTS'(1) << r_id;
                        r_valid  <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= ARB_SERVING;
                    end else if (!pending_ints[r_id]) begin
                        r_valid <= 1'b0;
                        r_state <= ARB_IDLE;
                    end
                end
                ARB_SERVING: begin
                    if (irq_done) begin
                        r_cnt   <= '0;
                        r_state <= ARB_IDLE;
                    end else if (TIMEOUT_CYCLES != 0 && r_cnt == CNT_LAST) begin
                        r_tpulse <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ARB_IDLE;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign irq_valid     = r_valid;
    assign irq_id        = r_id;
    assign int_clears    = r_clears;
    assign timeout_pulse = r_tpulse;
    assign busy          = (r_state != ARB_IDLE);

endmodule
